// File: rtl/return_address_stack.sv
// Return address stack: calls push return addresses, returns pop them, checkpoints repair speculation.
// Latency: one cycle; every update appears on top/ckpt outputs the cycle after the edge.
// Backpressure: none; push, pop and recover are accepted every cycle (rst > recover > push/pop).
module return_address_stack #(
    parameter int DEPTH     = 8,
    parameter int PC_WIDTH  = 32,
    parameter int PTR_WIDTH = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pushEn,
    input  logic [PC_WIDTH-1:0]  pushAddr,
    input  logic                 popEn,
    output logic [PC_WIDTH-1:0]  topAddr,
    output logic                 topValid,
    output logic [PTR_WIDTH-1:0] ckptPtr,
    output logic [PTR_WIDTH:0]   ckptCount,
    output logic [PC_WIDTH-1:0]  ckptTop,
    input  logic                 recoverEn,
    input  logic [PTR_WIDTH-1:0] recoverPtr,
    input  logic [PTR_WIDTH:0]   recoverCount,
    input  logic [PC_WIDTH-1:0]  recoverTop
);

    localparam logic [PTR_WIDTH:0]   FULL    = (PTR_WIDTH + 1)'(DEPTH);
    localparam logic [PTR_WIDTH:0]   CNT_ONE = (PTR_WIDTH + 1)'(1);
    localparam logic [PTR_WIDTH-1:0] PTR_ONE = PTR_WIDTH'(1);

    logic [PC_WIDTH-1:0]  entry [DEPTH];
    logic [PTR_WIDTH-1:0] ptr;
    logic [PTR_WIDTH:0]   count;

    logic [PTR_WIDTH-1:0] ptr_nxt;
    logic [PTR_WIDTH:0]   count_nxt;
    logic                 wr_en;
    logic [PTR_WIDTH-1:0] wr_idx;
    logic [PC_WIDTH-1:0]  wr_dat;

    // Next pointer/count and the single entry write for this cycle, recover first.
    always_comb begin
        ptr_nxt   = ptr;
        count_nxt = count;
        wr_en     = 1'b0;
        wr_idx    = ptr;
        wr_dat    = pushAddr;
        if (recoverEn) begin
            ptr_nxt   = recoverPtr;
            count_nxt = (recoverCount > FULL) ? FULL : recoverCount;
            wr_en     = 1'b1;
            wr_idx    = recoverPtr;
            wr_dat    = recoverTop;
        end else if (pushEn && popEn && (count != '0)) begin
            // Return then call in one group: replace the top in place.
            wr_en  = 1'b1;
            wr_idx = ptr;
        end else if (pushEn) begin
            // Full stack wraps and silently overwrites the oldest entry.
            ptr_nxt   = ptr + PTR_ONE;
            count_nxt = (count == FULL) ? count : count + CNT_ONE;
            wr_en     = 1'b1;
            wr_idx    = ptr + PTR_ONE;
        end else if (popEn && (count != '0)) begin
            // Popped contents stay in place so a later recovery can reuse them.
            ptr_nxt   = ptr - PTR_ONE;
            count_nxt = count - CNT_ONE;
        end
    end

    // State register with synchronous reset clearing pointer, count and all entries.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr   <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entry[i] <= '0;
            end
        end else begin
            ptr   <= ptr_nxt;
            count <= count_nxt;
            if (wr_en) begin
                entry[wr_idx] <= wr_dat;
            end
        end
    end

    // Outputs come straight from registers; the checkpoint is the pre-update state.
    always_comb begin
        topAddr   = entry[ptr];
        topValid  = (count != '0);
        ckptPtr   = ptr;
        ckptCount = count;
        ckptTop   = entry[ptr];
    end

endmodule
